// File: rtl/lcd_fb_writer_pkg.sv
// Shared framebuffer geometry, word type and capture FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Consumers: lcd_fb_writer, line_shadow_ram; COLLEN/LINES must match the image generator.
package configPackage;

   localparam int COLLEN = 75;   // words per stored line
   localparam int LINES  = 144;  // stored lines per frame

   typedef logic [35:0] fb_word_t;   // {slot0, slot1, slot2}
   typedef logic [11:0] pixel_t;     // {R[3:0], G[3:0], B[3:0]}

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      LINE    = 2'd1,
      FLUSH   = 2'd2
   } state_t;

endpackage

// File: rtl/lcd_fb_writer_shadow.sv
// line_shadow_ram: holds slot 0/1 pixels of the current line until the slot 2 pixel arrives.
// Latency: one write port; two read ports, each with a 1-cycle registered read.
// Backpressure: none; accepts one write and two reads every clk.
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr0_i/raddr1_i -> rdata0_o/rdata1_o read ports.
module line_shadow_ram
   import configPackage::*;
#(
   parameter int DEPTH = 2 * COLLEN,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  pixel_t        wdata_i,
   input  logic [AW-1:0] raddr0_i,
   input  logic [AW-1:0] raddr1_i,
   output pixel_t        rdata0_o,
   output pixel_t        rdata1_o
);

   pixel_t mem_q [DEPTH];
   pixel_t rdata0_q;
   pixel_t rdata1_q;

   // Contents are never reset: stale pixels are acceptable in flushed words.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata0_q <= mem_q[raddr0_i];
      rdata1_q <= mem_q[raddr1_i];
   end

   assign rdata0_o = rdata0_q;
   assign rdata1_o = rdata1_q;

endmodule

// File: rtl/lcd_fb_writer.sv
// lcd_fb_writer: captures the LCD RGB444 dot stream and packs 3 pixels per 36-bit framebuffer word.
// Latency: write presented 2 clk after the synchronized dot-clock edge is detected.
// Backpressure: none; pixels beyond 3*COLLEN or arriving during a flush are dropped and set overflow.
// Ports: clk/rst (sync, active-high); lcdDclk/lcdHsync/lcdVsync/lcdData async LCD pins;
//        fbWrAddr/fbWrData/fbWrEn framebuffer write port; frameDone pulse; overflow sticky flag.
// Build option: LCD_TESTPATTERN_EN replaces captured pixels with an x/line test pattern.
module lcd_fb_writer
   import configPackage::*;
#(
   parameter int COLLEN      = configPackage::COLLEN,
   parameter int LINES       = configPackage::LINES,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        lcdDclk,
   input  logic        lcdHsync,
   input  logic        lcdVsync,
   input  logic [11:0] lcdData,
   output logic [13:0] fbWrAddr,
   output logic [35:0] fbWrData,
   output logic        fbWrEn,
   output logic        frameDone,
   output logic        overflow
);

   localparam int WW  = $clog2(COLLEN);
   localparam int RAW = $clog2(2 * COLLEN);
   localparam int LW  = ($clog2(LINES) > 8) ? $clog2(LINES) : 8;

   localparam logic [8:0]     X_C2      = 9'(2 * COLLEN);
   localparam logic [8:0]     X_C3      = 9'(3 * COLLEN);
   localparam logic [8:0]     X_MAX     = 9'h1FF;
   localparam logic [WW-1:0]  W_LAST    = WW'(COLLEN - 1);
   localparam logic [LW-1:0]  L_LAST    = LW'(LINES - 1);
   localparam logic [13:0]    BASE_STEP = 14'(COLLEN);
   localparam logic [RAW-1:0] R_C1      = RAW'(COLLEN);

   // ---------------- input synchronizers and edge detect ----------------
   logic [SYNC_STAGES-1:0] dclk_sync_q, hs_sync_q, vs_sync_q;
   pixel_t                 dat_sync_q [SYNC_STAGES];
   logic                   dclk_dly_q, hs_dly_q, vs_dly_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         dclk_sync_q <= '0;
         hs_sync_q   <= '0;
         vs_sync_q   <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) dat_sync_q[i] <= '0;
         dclk_dly_q  <= 1'b0;
         hs_dly_q    <= 1'b0;
         vs_dly_q    <= 1'b0;
      end else begin
         dclk_sync_q   <= {dclk_sync_q[SYNC_STAGES-2:0], lcdDclk};
         hs_sync_q     <= {hs_sync_q[SYNC_STAGES-2:0], lcdHsync};
         vs_sync_q     <= {vs_sync_q[SYNC_STAGES-2:0], lcdVsync};
         dat_sync_q[0] <= lcdData;
         for (int i = 1; i < SYNC_STAGES; i++) dat_sync_q[i] <= dat_sync_q[i-1];
         dclk_dly_q    <= dclk_sync_q[SYNC_STAGES-1];
         hs_dly_q      <= hs_sync_q[SYNC_STAGES-1];
         vs_dly_q      <= vs_sync_q[SYNC_STAGES-1];
      end
   end

   logic dclk_e, hs_e, vs_e;
   assign dclk_e = dclk_sync_q[SYNC_STAGES-1] & ~dclk_dly_q;
   assign hs_e   = hs_sync_q[SYNC_STAGES-1] & ~hs_dly_q;
   assign vs_e   = vs_sync_q[SYNC_STAGES-1] & ~vs_dly_q;

   // ---------------- capture FSM ----------------
   state_t          state_q, state_d;
   logic [8:0]      x_q, x_d;
   logic [LW-1:0]   line_q, line_d;
   logic [13:0]     base_q, base_d;
   logic [WW-1:0]   fw_q, fw_d;
   logic            ovf_q, ovf_d;

   pixel_t pix_cap;
`ifdef LCD_TESTPATTERN_EN
   assign pix_cap = {x_q[3:0], line_q[3:0], x_q[7:4] ^ line_q[7:4]};
`else
   assign pix_cap = dat_sync_q[SYNC_STAGES-1];
`endif

   // Issue bundle: what enters the write pipeline this cycle.
   logic            iss_wr, iss_word, iss_fd, adv;
   logic [RAW-1:0]  iss_waddr;
   logic [WW-1:0]   iss_widx, fw_start;
   pixel_t          iss_pix;
   logic [8:0]      x_nxt;

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      line_d    = line_q;
      base_d    = base_q;
      fw_d      = fw_q;
      ovf_d     = ovf_q;
      iss_wr    = 1'b0;
      iss_word  = 1'b0;
      iss_fd    = 1'b0;
      iss_waddr = '0;
      iss_widx  = '0;
      iss_pix   = '0;
      adv       = 1'b0;
      fw_start  = '0;
      x_nxt     = x_q;

      if (vs_e) begin
         state_d = LINE;
         x_d     = '0;
         line_d  = '0;
         base_d  = '0;
         fw_d    = '0;
      end else begin
         case (state_q)
            LINE: begin
               if (dclk_e) begin
                  x_nxt = (x_q == X_MAX) ? x_q : x_q + 9'd1;
                  if (x_q < X_C2) begin
                     iss_wr    = 1'b1;
                     iss_waddr = x_q[RAW-1:0];
                     iss_pix   = pix_cap;
                  end else if (x_q < X_C3) begin
                     iss_word = 1'b1;
                     iss_widx = WW'(x_q - X_C2);
                     iss_pix  = pix_cap;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               x_d = x_nxt;
               if (hs_e) begin
                  if (x_nxt >= X_C3) begin
                     adv = 1'b1;
                  end else begin
                     fw_start = (x_nxt > X_C2) ? WW'(x_nxt - X_C2) : '0;
                     if (dclk_e) begin
                        // Pipeline slot taken by the pixel; flush starts next cycle.
                        fw_d    = fw_start;
                        state_d = FLUSH;
                     end else begin
                        iss_word = 1'b1;
                        iss_widx = fw_start;
                        if (fw_start == W_LAST) begin
                           adv = 1'b1;
                        end else begin
                           fw_d    = fw_start + WW'(1);
                           state_d = FLUSH;
                        end
                     end
                  end
               end
            end
            FLUSH: begin
               if (dclk_e) ovf_d = 1'b1;
               iss_word = 1'b1;
               iss_widx = fw_q;
               if (fw_q == W_LAST) adv = 1'b1;
               else                fw_d = fw_q + WW'(1);
            end
            default: ;
         endcase

         if (adv) begin
            x_d    = '0;
            base_d = base_q + BASE_STEP;
            line_d = line_q + LW'(1);
            if (line_q == L_LAST) begin
               iss_fd  = 1'b1;
               state_d = WAIT_VS;
            end else begin
               state_d = LINE;
            end
         end
      end
   end

   // ---------------- write pipeline ----------------
   logic            s1_wr_q, s1_word_q, s1_fd_q;
   logic [RAW-1:0]  s1_waddr_q;
   logic [WW-1:0]   s1_widx_q;
   pixel_t          s1_pix_q;
   logic [13:0]     s1_addr_q;
   logic            wr_en_q, fd2_q, done_q;
   logic [13:0]     wr_addr_q;
   pixel_t          pix2_q;
   pixel_t          rd0, rd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WAIT_VS;
         x_q        <= '0;
         line_q     <= '0;
         base_q     <= '0;
         fw_q       <= '0;
         ovf_q      <= 1'b0;
         s1_wr_q    <= 1'b0;
         s1_word_q  <= 1'b0;
         s1_fd_q    <= 1'b0;
         s1_waddr_q <= '0;
         s1_widx_q  <= '0;
         s1_pix_q   <= '0;
         s1_addr_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         pix2_q     <= '0;
         fd2_q      <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         line_q     <= line_d;
         base_q     <= base_d;
         fw_q       <= fw_d;
         ovf_q      <= ovf_d;
         s1_wr_q    <= iss_wr;
         s1_word_q  <= iss_word;
         s1_fd_q    <= iss_fd;
         s1_waddr_q <= iss_waddr;
         s1_widx_q  <= iss_widx;
         s1_pix_q   <= iss_pix;
         s1_addr_q  <= base_q + 14'(iss_widx);
         wr_en_q    <= s1_word_q;
         if (s1_word_q) wr_addr_q <= s1_addr_q;
         pix2_q     <= s1_pix_q;
         fd2_q      <= s1_fd_q;
         done_q     <= fd2_q;
      end
   end

   line_shadow_ram #(.DEPTH(2 * COLLEN), .AW(RAW)) u_shadow (
      .clk      (clk),
      .we_i     (s1_wr_q),
      .waddr_i  (s1_waddr_q),
      .wdata_i  (s1_pix_q),
      .raddr0_i (RAW'(s1_widx_q)),
      .raddr1_i (RAW'(s1_widx_q) + R_C1),
      .rdata0_o (rd0),
      .rdata1_o (rd1)
   );

   // Read registers are not reset, so data is forced to 0 outside write strobes.
   assign fbWrData  = wr_en_q ? {rd0, rd1, pix2_q} : 36'd0;
   assign fbWrEn    = wr_en_q;
   assign fbWrAddr  = wr_addr_q;
   assign frameDone = done_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_lcd_fb_writer.sv
// Directed bench for lcd_fb_writer: line packing, flush, overflow, vsync restart, frame end, reset abort.
// Latency: n/a.
// Backpressure: n/a.
module tb_lcd_fb_writer;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        lcdDclk  = 1'b0;
   logic        lcdHsync = 1'b0;
   logic        lcdVsync = 1'b0;
   logic [11:0] lcdData  = 12'h000;
   logic [13:0] fbWrAddr;
   logic [35:0] fbWrData;
   logic        fbWrEn;
   logic        frameDone;
   logic        overflow;

   int n_vec  = 0;
   int n_err  = 0;
   int fd_cnt = 0;
   int fd0;
   int n0;

   logic [13:0] q_addr [$];
   logic [35:0] q_dat  [$];

   lcd_fb_writer dut (
      .clk       (clk),
      .rst       (rst),
      .lcdDclk   (lcdDclk),
      .lcdHsync  (lcdHsync),
      .lcdVsync  (lcdVsync),
      .lcdData   (lcdData),
      .fbWrAddr  (fbWrAddr),
      .fbWrData  (fbWrData),
      .fbWrEn    (fbWrEn),
      .frameDone (frameDone),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Write log, sampled away from the active edge.
   always @(negedge clk) begin
      if (fbWrEn) begin
         q_addr.push_back(fbWrAddr);
         q_dat.push_back(fbWrData);
      end
      if (frameDone) fd_cnt++;
   end

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pix(input logic [11:0] d);
      @(negedge clk); lcdData = d;
      @(negedge clk); lcdDclk = 1'b1;
      repeat (2) @(negedge clk);
      lcdDclk = 1'b0;
      @(negedge clk);
   endtask

   task automatic pixels(input int n, input logic [11:0] base);
      for (int i = 0; i < n; i++) pix(base + 12'(i));
   endtask

   task automatic hs_pulse(input int settle);
      lcdHsync = 1'b1;
      repeat (2) @(negedge clk);
      lcdHsync = 1'b0;
      repeat (settle) @(negedge clk);
   endtask

   task automatic vs_pulse();
      lcdVsync = 1'b1;
      repeat (2) @(negedge clk);
      lcdVsync = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic clear_log();
      q_addr.delete();
      q_dat.delete();
   endtask

   initial begin
      // Reset state
      idle(3);
      chk("rst_en",   36'(fbWrEn),    36'd0);
      chk("rst_data", fbWrData,       36'd0);
      chk("rst_addr", 36'(fbWrAddr),  36'd0);
      chk("rst_done", 36'(frameDone), 36'd0);
      chk("rst_ovf",  36'(overflow),  36'd0);
      rst = 1'b0;
      idle(2);
      vs_pulse();

      // Full 225-pixel line, value = x, line 0 (base 0)
      clear_log();
      pixels(225, 12'h000);
      idle(6);
      chk("full_cnt",    36'(q_addr.size()), 36'd75);
      chk("full_addr0",  36'(q_addr[0]),     36'd0);
      chk("full_word0",  q_dat[0],           36'h000_04B_096);
      chk("full_addr74", 36'(q_addr[74]),    36'd74);
      chk("full_word74", q_dat[74],          36'h04A_095_0E0);
      chk("full_ovf",    36'(overflow),      36'd0);
      hs_pulse(10);
      chk("full_hs_nowr", 36'(q_addr.size()), 36'd75);

      // 224-pixel line then hsync, line 1 (base 75)
      clear_log();
      pixels(224, 12'h000);
      idle(6);
      chk("short_cnt",    36'(q_addr.size()), 36'd74);
      chk("short_addr73", 36'(q_addr[73]),    36'd148);
      chk("short_word73", q_dat[73],          36'h049_094_0DF);
      hs_pulse(100);
      chk("flush_cnt",    36'(q_addr.size()), 36'd75);
      chk("flush_addr",   36'(q_addr[74]),    36'd149);
      chk("flush_word",   q_dat[74],          36'h04A_095_000);
      chk("flush_ovf",    36'(overflow),      36'd0);

      // 230-pixel line, line 2 (base 150): 5 pixels dropped
      clear_log();
      pixels(230, 12'h000);
      idle(6);
      chk("ovl_cnt",    36'(q_addr.size()), 36'd75);
      chk("ovl_addr74", 36'(q_addr[74]),    36'd224);
      chk("ovl_word74", q_dat[74],          36'h04A_095_0E0);
      chk("ovl_flag",   36'(overflow),      36'd1);
      hs_pulse(10);
      vs_pulse();
      chk("ovl_sticky", 36'(overflow),      36'd1);

      // Ten flush-only lines, then vsync in the middle of line 10
      clear_log();
      repeat (10) hs_pulse(90);
      chk("vsmid_cnt",  36'(q_addr.size()),              36'd750);
      chk("vsmid_last", 36'(q_addr[q_addr.size() - 1]),  36'd749);
      pixels(50, 12'hA00);
      idle(4);
      chk("vsmid_nowr", 36'(q_addr.size()), 36'd750);
      vs_pulse();
      clear_log();
      pixels(225, 12'h300);
      idle(6);
      chk("vsnew_cnt",   36'(q_addr.size()), 36'd75);
      chk("vsnew_addr0", 36'(q_addr[0]),     36'd0);
      chk("vsnew_word0", q_dat[0],           36'h300_34B_396);

      // Whole frame of 144 flush-only lines
      vs_pulse();
      clear_log();
      fd0 = fd_cnt;
      repeat (144) hs_pulse(90);
      chk("frame_cnt",   36'(q_addr.size()),             36'd10800);
      chk("frame_first", 36'(q_addr[0]),                 36'd0);
      chk("frame_last",  36'(q_addr[q_addr.size() - 1]), 36'd10799);
      chk("frame_done",  36'(fd_cnt - fd0),              36'd1);
      clear_log();
      pixels(5, 12'h123);
      hs_pulse(90);
      chk("frame_idle_nowr", 36'(q_addr.size()), 36'd0);
      chk("frame_done_once", 36'(fd_cnt - fd0),  36'd1);

      // Reset while a slot-2 write is in flight
      vs_pulse();
      clear_log();
      pixels(160, 12'h000);
      idle(6);
      chk("abort_pre_cnt", 36'(q_addr.size()), 36'd10);
      chk("abort_pre_ovf", 36'(overflow),      36'd1);
      n0 = q_addr.size();
      @(negedge clk); lcdData = 12'h555;
      @(negedge clk); lcdDclk = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_en",   36'(fbWrEn),    36'd0);
      chk("abort_data", fbWrData,       36'd0);
      chk("abort_addr", 36'(fbWrAddr),  36'd0);
      chk("abort_done", 36'(frameDone), 36'd0);
      chk("abort_ovf",  36'(overflow),  36'd0);
      rst = 1'b0;
      lcdDclk = 1'b0;
      idle(4);
      pixels(10, 12'h000);
      hs_pulse(90);
      chk("abort_nowr", 36'(q_addr.size()), 36'(n0));
      vs_pulse();
      clear_log();
      pixels(225, 12'h000);
      idle(6);
      chk("resume_cnt",   36'(q_addr.size()), 36'd75);
      chk("resume_addr0", 36'(q_addr[0]),     36'd0);
      chk("resume_word0", q_dat[0],           36'h000_04B_096);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
